collatz_range_engine: RTL



---
 rtl/collatz_range_engine_pkg.sv | 24 ++
 rtl/collatz_range_engine_if.sv | 29 ++
 rtl/collatz_range_engine_iter.sv | 45 ++++
 rtl/collatz_range_engine.sv | 122 ++++++++++++
 4 files changed

// File: rtl/collatz_range_engine_pkg.sv
// Shared state encoding and the 32-bit Collatz step for the range engine.
// Pure types/functions: no latency, no flow control.
package collatz_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ITER  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // 3n+1 wraps modulo 2**32 by construction of the 32-bit result.
    function automatic logic [31:0] collatz_next(input logic [31:0] n);
        logic [31:0] r;
        if (n[0]) begin
            r = (n << 1) + n + 32'd1;
        end else begin
            r = n >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/collatz_range_engine_if.sv
// Run request / result bundle between the lab1 controller and the range engine.
// No backpressure: go is a request pulse, done a completion pulse, count a registered read.
interface collatz_range_engine_if #(
    parameter int COUNT_BITS = 16
) ();

    logic                  go;
    logic [31:0]           start;
    logic                  done;
    logic                  busy;
    logic [COUNT_BITS-1:0] count;

    modport master (
        output go,
        output start,
        input  done,
        input  busy,
        input  count
    );

    modport slave (
        input  go,
        input  start,
        output done,
        output busy,
        output count
    );

endinterface

// File: rtl/collatz_range_engine_iter.sv
// Single-value Collatz iterator: one step per cycle while i_step, saturating term count.
// Result ready when o_fin (n is 0 or 1); no backpressure, caller stops stepping on o_fin.
module collatz_iter
    import collatz_pkg::*;
#(
    parameter int COUNT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_load,
    input  logic [31:0]           i_value,
    input  logic                  i_step,
    output logic [COUNT_BITS-1:0] o_cnt,
    output logic                  o_fin
);

    localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [COUNT_BITS-1:0] CNT_ONE = {{(COUNT_BITS-1){1'b0}}, 1'b1};

    logic [31:0]           r_n;
    logic [COUNT_BITS-1:0] r_cnt;
    logic                  w_fin;

    // 0 is never iterated; 1 is the natural end of every sequence.
    assign w_fin = (r_n == 32'd0) || (r_n == 32'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_n   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_n   <= i_value;
            r_cnt <= (i_value == 32'd0) ? '0 : CNT_ONE;
        end else if (i_step && !w_fin) begin
            r_n <= collatz_next(r_n);
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_fin = w_fin;

endmodule

// File: rtl/collatz_range_engine.sv
// Computes Collatz lengths for RAM_WORDS values from start on go; 3+(len-1) cycles per word.
// No backpressure: go ignored unless idle; count is a 1-cycle registered read of mem[start].
module collatz_range_engine
    import collatz_pkg::*;
#(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8,
    parameter int COUNT_BITS    = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    collatz_range_engine_if.slave  bus
);

    localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);
    localparam logic [RAM_ADDR_BITS-1:0] IDX_ONE  = {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};

    state_t                   r_state;
    state_t                   w_next;
    logic [31:0]              r_base;
    logic [RAM_ADDR_BITS-1:0] r_index;
    logic [COUNT_BITS-1:0]    r_count;
    logic [COUNT_BITS-1:0]    r_mem [RAM_WORDS];

    logic                     w_capture;
    logic                     w_load;
    logic                     w_step;
    logic                     w_wr;
    logic                     w_done;
    logic                     w_busy;
    logic                     w_last;
    logic                     w_fin;
    logic [31:0]              w_value;
    logic [COUNT_BITS-1:0]    w_cnt;

    assign w_last  = (r_index == LAST_IDX);
    assign w_value = r_base + {{(32-RAM_ADDR_BITS){1'b0}}, r_index};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.go) w_next = LOAD;
            LOAD:    w_next = ITER;
            ITER:    if (w_fin) w_next = WRITE;
            WRITE:   w_next = w_last ? DONE : LOAD;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_capture = 1'b0;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_wr      = 1'b0;
        w_done    = 1'b0;
        w_busy    = 1'b1;
        case (r_state)
            IDLE: begin
                w_capture = bus.go;
                w_busy    = 1'b0;
            end
            LOAD:    w_load = 1'b1;
            ITER:    w_step = 1'b1;
            WRITE:   w_wr   = 1'b1;
            DONE:    w_done = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base  <= '0;
            r_index <= '0;
        end else if (w_capture) begin
            r_base  <= bus.start;
            r_index <= '0;
        end else if (w_wr && !w_last) begin
            r_index <= r_index + IDX_ONE;
        end
    end

    collatz_iter #(
        .COUNT_BITS (COUNT_BITS)
    ) u_iter (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_value (w_value),
        .i_step  (w_step),
        .o_cnt   (w_cnt),
        .o_fin   (w_fin)
    );

    // Result RAM keeps its contents across reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_index] <= w_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else begin
            r_count <= r_mem[bus.start[RAM_ADDR_BITS-1:0]];
        end
    end

    assign bus.done  = w_done;
    assign bus.busy  = w_busy;
    assign bus.count = r_count;

endmodule
